freq_sel_ctrl: RTL and testbench

Button-driven frequency-select controller that sits directly upstream of the 100 MHz programmable clock divider and drives its 4-bit rate select `S1`. Two push-buttons (up/down) are synchronized, debounced and turned into press events with hold-to-repeat. The events step a saturating selector within 1..8. A one-cycle strobe marks every change, so display logic can refresh.

---
 rtl/freq_sel_pkg.sv | 16 +
 rtl/btn_debounce.sv | 114 +++++++++++
 rtl/freq_sel_ctrl.sv | 76 +++++++
 tb/tb_freq_sel_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_sel_pkg.sv
// freq_sel_pkg: shared constants and types for the frequency-select path.
// The divider also imports SEL_W so both sides agree on the select width.
package freq_sel_pkg;

    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_MIN = 4'd1;
    localparam logic [SEL_W-1:0] SEL_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RPT
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debouncer and hold-to-repeat
// FSM for one push-button; emits a registered one-cycle step pulse.
module btn_debounce
    import freq_sel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 20_000_000
) (
    input  logic CLKin,
    input  logic Rst,
    input  logic btn,
    input  logic hold_off,
    output logic db,
    output logic step
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMAX =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TW = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DLY_TC = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RPT_TC = TW'(REPEAT_RATE - 1);

    logic          sync1;
    logic          sync2;
    logic          db_q;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tmr;
    rpt_state_t    state;

    always_ff @(posedge CLKin or posedge Rst) begin
        if (Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any sample matching the current level restarts the count.
    always_ff @(posedge CLKin or posedge Rst) begin
        if (Rst) begin
            db   <= 1'b0;
            dcnt <= '0;
        end else if (sync2 == db) begin
            dcnt <= '0;
        end else if (dcnt == DEB_TC) begin
            db   <= sync2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Press needs a true rising edge of db, so a button still held when
    // the other is released cannot fire from IDLE.
    always_ff @(posedge CLKin or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
            step  <= 1'b0;
            db_q  <= 1'b0;
        end else begin
            db_q <= db;
            step <= 1'b0;
            if (hold_off) begin
                state <= ST_IDLE;
                tmr   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (db && !db_q) begin
                            step  <= 1'b1;
                            state <= ST_WAIT;
                            tmr   <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (!db) begin
                            state <= ST_IDLE;
                            tmr   <= '0;
                        end else if (tmr == DLY_TC) begin
                            step  <= 1'b1;
                            state <= ST_RPT;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!db) begin
                            state <= ST_IDLE;
                            tmr   <= '0;
                        end else if (tmr == RPT_TC) begin
                            step <= 1'b1;
                            tmr  <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/freq_sel_ctrl.sv
// freq_sel_ctrl: up/down buttons step a saturating 1..8 rate select for
// the clock divider, with a one-cycle change strobe.
module freq_sel_ctrl
    import freq_sel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 20_000_000,
    parameter int unsigned SEL_INIT     = 1
) (
    input  logic             CLKin,
    input  logic             Rst,
    input  logic             BtnUp,
    input  logic             BtnDn,
    output logic [SEL_W-1:0] S1,
    output logic             Chg
);

    localparam logic [SEL_W-1:0] INIT_V = SEL_W'(SEL_INIT);

    logic db_up;
    logic db_dn;
    logic st_up;
    logic st_dn;
    logic both;
    logic up_ev;
    logic dn_ev;

    assign both  = db_up & db_dn;
    assign up_ev = st_up & ~st_dn & ~both;
    assign dn_ev = st_dn & ~st_up & ~both;

    btn_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_up (
        .CLKin   (CLKin),
        .Rst     (Rst),
        .btn     (BtnUp),
        .hold_off(both),
        .db      (db_up),
        .step    (st_up)
    );

    btn_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_dn (
        .CLKin   (CLKin),
        .Rst     (Rst),
        .btn     (BtnDn),
        .hold_off(both),
        .db      (db_dn),
        .step    (st_dn)
    );

    // S1 feeds the divider combinationally, so it comes straight from flops.
    always_ff @(posedge CLKin or posedge Rst) begin
        if (Rst) begin
            S1  <= INIT_V;
            Chg <= 1'b0;
        end else begin
            Chg <= 1'b0;
            if (up_ev && S1 < SEL_MAX) begin
                S1  <= S1 + 1'b1;
                Chg <= 1'b1;
            end else if (dn_ev && S1 > SEL_MIN) begin
                S1  <= S1 - 1'b1;
                Chg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// tb_freq_sel_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a window/age based reference model.
module tb_freq_sel_ctrl;

    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic       CLKin = 1'b0;
    logic       Rst   = 1'b1;
    logic       BtnUp = 1'b0;
    logic       BtnDn = 1'b0;
    logic [3:0] S1;
    logic       Chg;

    int n_chk = 0;
    int n_err = 0;

    freq_sel_ctrl #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE),
        .SEL_INIT    (1)
    ) dut (
        .CLKin(CLKin),
        .Rst  (Rst),
        .BtnUp(BtnUp),
        .BtnDn(BtnDn),
        .S1   (S1),
        .Chg  (Chg)
    );

    always #5 CLKin = ~CLKin;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLKin);
    endtask

    // Reference model.
    // db flips once the last DEB synchronized samples all disagree with it.
    // A press session starts one cycle after db rises; events fire at
    // age 0, DLY, DLY+RATE, ... and take effect on S1 one cycle later.
    int m_s1  = 1;
    int m_chg = 0;
    int since [2];
    bit mdb   [2];
    bit mdbp  [2];
    bit ev    [2];
    bit rh    [2][DEB+2];

    task automatic model_reset();
        m_s1  = 1;
        m_chg = 0;
        for (int b = 0; b < 2; b++) begin
            since[b] = -1;
            mdb[b]   = 1'b0;
            mdbp[b]  = 1'b0;
            ev[b]    = 1'b0;
            for (int j = 0; j < DEB + 2; j++) rh[b][j] = 1'b0;
        end
    endtask

    always @(posedge CLKin or posedge Rst) begin
        bit bothp;
        bit allne;
        if (Rst) begin
            model_reset();
        end else begin
            bothp = mdb[0] && mdb[1];
            m_chg = 0;
            if (!bothp && ev[0] && !ev[1] && m_s1 < 8) begin
                m_s1++;
                m_chg = 1;
            end else if (!bothp && ev[1] && !ev[0] && m_s1 > 1) begin
                m_s1--;
                m_chg = 1;
            end
            for (int b = 0; b < 2; b++) begin
                ev[b] = 1'b0;
                if (since[b] >= 0) begin
                    if (!mdb[b] || bothp) begin
                        since[b] = -1;
                    end else begin
                        since[b]++;
                        ev[b] = (since[b] == DLY) ||
                                (since[b] > DLY &&
                                 (since[b] - DLY) % RATE == 0);
                    end
                end else if (mdb[b] && !mdbp[b] && !bothp) begin
                    since[b] = 0;
                    ev[b]    = 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                for (int j = DEB + 1; j > 0; j--) rh[b][j] = rh[b][j-1];
                rh[b][0] = (b == 0) ? BtnUp : BtnDn;
                allne = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (rh[b][j] == mdb[b]) allne = 1'b0;
                mdbp[b] = mdb[b];
                if (allne) mdb[b] = !mdb[b];
            end
        end
    end

    always @(negedge CLKin) begin
        chk("s1", S1, m_s1);
        chk("chg", Chg, m_chg);
        chk("range", (S1 >= 4'd1 && S1 <= 4'd8), 1);
    end

    task automatic mid_reset(input string tag);
        #2 Rst = 1'b1;
        #1;
        chk({tag, "_s1"}, S1, 1);
        chk({tag, "_chg"}, Chg, 0);
        @(negedge CLKin);
        Rst = 1'b0;
    endtask

    task automatic count_chg(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (Chg) c++;
        end
    endtask

    initial begin
        int c;
        model_reset();
        cyc(3);
        chk("rst_s1", S1, 1);
        chk("rst_chg", Chg, 0);
        Rst = 1'b0;
        cyc(2);

        // bounce, then hold
        for (int i = 0; i < 5; i++) begin
            BtnUp = 1'b1; cyc(2);
            BtnUp = 1'b0; cyc(2);
        end
        BtnUp = 1'b1;
        cyc(7);
        chk("bounce_pre", S1, 1);
        cyc(1);
        chk("bounce_inc", S1, 2);
        chk("bounce_chg", Chg, 1);
        BtnUp = 1'b0;
        count_chg(12, c);
        chk("bounce_one", c, 0);
        mid_reset("rst_mid");
        cyc(2);

        // repeat and saturation
        BtnUp = 1'b1;
        cyc(8);
        chk("rpt_2", S1, 2);
        for (int s = 3; s <= 8; s++) begin
            cyc(s == 3 ? DLY : RATE);
            chk("rpt_step", S1, s);
        end
        count_chg(40, c);
        chk("sat_nochg", c, 0);
        chk("sat_8", S1, 8);
        BtnUp = 1'b0;
        cyc(12);

        // lower limit
        mid_reset("rst_lo");
        BtnDn = 1'b1;
        count_chg(40, c);
        chk("lo_nochg", c, 0);
        chk("lo_s1", S1, 1);
        BtnDn = 1'b0;
        cyc(12);

        // both held
        for (int i = 0; i < 4; i++) begin
            BtnUp = 1'b1; cyc(10);
            BtnUp = 1'b0; cyc(10);
        end
        chk("both_start", S1, 5);
        BtnUp = 1'b1;
        count_chg(10, c);
        BtnDn = 1'b1;
        begin
            int c2;
            count_chg(100, c2);
            chk("both_chgs", c + c2, 1);
        end
        chk("both_s1", S1, 6);
        BtnUp = 1'b0;
        count_chg(50, c);
        chk("both_rel_nochg", c, 0);
        chk("both_rel_s1", S1, 6);
        BtnDn = 1'b0;
        cyc(12);
        BtnDn = 1'b1;
        cyc(8);
        chk("both_redn", S1, 5);
        BtnDn = 1'b0;
        cyc(12);

        // up to 8, then reset mid-repeat of down
        BtnUp = 1'b1;
        cyc(40);
        BtnUp = 1'b0;
        cyc(12);
        chk("top_8", S1, 8);
        BtnDn = 1'b1;
        cyc(38);
        chk("dn_rpt", S1, 5);
        mid_reset("rst_rpt");
        count_chg(40, c);
        chk("rst_rpt_nochg", c, 0);
        chk("rst_rpt_s1", S1, 1);
        BtnDn = 1'b0;
        cyc(12);

        // held through reset: exactly one event after re-debounce
        BtnUp = 1'b1;
        cyc(4);
        mid_reset("rst_hold");
        cyc(12);
        chk("hold_one", S1, 2);
        BtnUp = 1'b0;
        cyc(12);

        // random traffic
        for (int r = 0; r < 80; r++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 9);
            len  = $urandom_range(1, 45);
            if (mode == 0) begin
                #2 Rst = 1'b1;
                @(negedge CLKin);
                Rst = 1'b0;
            end else if (mode == 9) begin
                for (int i = 0; i < len; i++) begin
                    BtnUp = 1'($urandom_range(0, 1));
                    BtnDn = 1'($urandom_range(0, 1));
                    cyc(1);
                end
            end else begin
                BtnUp = (mode <= 4) || (mode == 7);
                BtnDn = (mode == 5) || (mode == 6) || (mode == 7);
                cyc(len);
            end
        end
        BtnUp = 1'b0;
        BtnDn = 1'b0;
        cyc(30);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
